// File: rtl/mrr_loopback_push_arbiter.sv
// Round-robin arbiter that forwards one requester's chip ID and message to the
// loopback queue push port, then returns an ack or timeout error to that requester.
module mrr_loopback_push_arbiter #(
  parameter int unsigned NUM_SRC              = 4,
  parameter int unsigned CHIP_ID_LEN          = 8,
  parameter int unsigned LOOPBACK_MESSAGE_LEN = 64,
  parameter int unsigned TIMEOUT_CYCLES       = 1024
) (
  input  logic                                    clk,
  input  logic                                    rst,
  input  logic [NUM_SRC-1:0]                      src_request,
  input  logic [NUM_SRC*CHIP_ID_LEN-1:0]          src_chip_id,
  input  logic [NUM_SRC*LOOPBACK_MESSAGE_LEN-1:0] src_message,
  output logic [NUM_SRC-1:0]                      src_ack,
  output logic [NUM_SRC-1:0]                      src_error,
  output logic                                    push_request,
  output logic [CHIP_ID_LEN-1:0]                  push_chip_id,
  output logic [LOOPBACK_MESSAGE_LEN-1:0]         push_message,
  input  logic                                    push_ack,
  output logic                                    busy,
  output logic [15:0]                             push_count,
  output logic [15:0]                             timeout_count
);

  localparam int unsigned IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int unsigned CNT_W = 16;
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(NUM_SRC - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PUSH,
    S_RELEASE,
    S_SRC_ACK,
    S_SRC_ERR
  } state_t;

  state_t                            state_q, state_d;
  logic [IDX_W-1:0]                  grant_q, grant_d;
  logic [IDX_W-1:0]                  last_grant_q, last_grant_d;
  logic [CNT_W-1:0]                  tmo_cnt_q, tmo_cnt_d;
  logic                              push_request_q, push_request_d;
  logic [CHIP_ID_LEN-1:0]            push_chip_id_q, push_chip_id_d;
  logic [LOOPBACK_MESSAGE_LEN-1:0]   push_message_q, push_message_d;
  logic [NUM_SRC-1:0]                src_ack_q, src_ack_d;
  logic [NUM_SRC-1:0]                src_error_q, src_error_d;
  logic                              busy_q, busy_d;
  logic [15:0]                       push_count_q, push_count_d;
  logic [15:0]                       timeout_count_q, timeout_count_d;

  logic [IDX_W-1:0]                  rr_idx_c;
  logic                              rr_found_c;

  // First requester strictly after the last served one, wrapping around.
  always_comb begin
    rr_idx_c   = last_grant_q;
    rr_found_c = 1'b0;
    for (int unsigned k = 1; k <= NUM_SRC; k++) begin
      if (!rr_found_c && src_request[IDX_W'((32'(last_grant_q) + k) % NUM_SRC)]) begin
        rr_found_c = 1'b1;
        rr_idx_c   = IDX_W'((32'(last_grant_q) + k) % NUM_SRC);
      end
    end
  end

  // Next-state, datapath and registered-output computation.
  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    last_grant_d    = last_grant_q;
    tmo_cnt_d       = tmo_cnt_q;
    push_chip_id_d  = push_chip_id_q;
    push_message_d  = push_message_q;
    push_count_d    = push_count_q;
    timeout_count_d = timeout_count_q;

    case (state_q)
      S_IDLE: begin
        if (rr_found_c) begin
          grant_d        = rr_idx_c;
          push_chip_id_d = src_chip_id[32'(rr_idx_c) * CHIP_ID_LEN +: CHIP_ID_LEN];
          push_message_d = src_message[32'(rr_idx_c) * LOOPBACK_MESSAGE_LEN +: LOOPBACK_MESSAGE_LEN];
          tmo_cnt_d      = '0;
          state_d        = S_PUSH;
        end
      end
      S_PUSH: begin
        tmo_cnt_d = tmo_cnt_q + CNT_W'(1);
        // An ack on the final allowed cycle still counts as success.
        if (push_ack) begin
          state_d      = S_RELEASE;
          push_count_d = push_count_q + 16'd1;
        end else if (tmo_cnt_q == TIMEOUT_LAST) begin
          state_d = S_SRC_ERR;
          if (timeout_count_q != 16'hFFFF) begin
            timeout_count_d = timeout_count_q + 16'd1;
          end
        end
      end
      S_RELEASE: begin
        if (!push_ack) begin
          state_d = S_SRC_ACK;
        end
      end
      S_SRC_ACK, S_SRC_ERR: begin
        if (!src_request[grant_q]) begin
          state_d      = S_IDLE;
          last_grant_d = grant_q;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Outputs are registered images of the state being entered.
    push_request_d = (state_d == S_PUSH);
    busy_d         = (state_d != S_IDLE);
    src_ack_d      = (state_d == S_SRC_ACK) ? (NUM_SRC'(1) << grant_d) : '0;
    src_error_d    = (state_d == S_SRC_ERR) ? (NUM_SRC'(1) << grant_d) : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= S_IDLE;
      grant_q         <= '0;
      last_grant_q    <= LAST_IDX;
      tmo_cnt_q       <= '0;
      push_request_q  <= 1'b0;
      push_chip_id_q  <= '0;
      push_message_q  <= '0;
      src_ack_q       <= '0;
      src_error_q     <= '0;
      busy_q          <= 1'b0;
      push_count_q    <= '0;
      timeout_count_q <= '0;
    end else begin
      state_q         <= state_d;
      grant_q         <= grant_d;
      last_grant_q    <= last_grant_d;
      tmo_cnt_q       <= tmo_cnt_d;
      push_request_q  <= push_request_d;
      push_chip_id_q  <= push_chip_id_d;
      push_message_q  <= push_message_d;
      src_ack_q       <= src_ack_d;
      src_error_q     <= src_error_d;
      busy_q          <= busy_d;
      push_count_q    <= push_count_d;
      timeout_count_q <= timeout_count_d;
    end
  end

  assign push_request  = push_request_q;
  assign push_chip_id  = push_chip_id_q;
  assign push_message  = push_message_q;
  assign src_ack       = src_ack_q;
  assign src_error     = src_error_q;
  assign busy          = busy_q;
  assign push_count    = push_count_q;
  assign timeout_count = timeout_count_q;

endmodule

// File: tb/tb_mrr_loopback_push_arbiter.sv
// Bench for mrr_loopback_push_arbiter: directed scenarios plus randomized traffic,
// all outputs compared every cycle against a transaction-level reference thread.
module tb_mrr_loopback_push_arbiter;

  localparam int unsigned N  = 4;
  localparam int unsigned CW = 8;
  localparam int unsigned MW = 64;
  localparam int unsigned T  = 16;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    src_request = '0;
  logic [N*CW-1:0] src_chip_id = '0;
  logic [N*MW-1:0] src_message = '0;
  logic [N-1:0]    src_ack;
  logic [N-1:0]    src_error;
  logic            push_request;
  logic [CW-1:0]   push_chip_id;
  logic [MW-1:0]   push_message;
  logic            push_ack = 1'b0;
  logic            busy;
  logic [15:0]     push_count;
  logic [15:0]     timeout_count;

  mrr_loopback_push_arbiter #(
    .NUM_SRC(N), .CHIP_ID_LEN(CW), .LOOPBACK_MESSAGE_LEN(MW), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .rst(rst), .src_request(src_request), .src_chip_id(src_chip_id),
    .src_message(src_message), .src_ack(src_ack), .src_error(src_error),
    .push_request(push_request), .push_chip_id(push_chip_id), .push_message(push_message),
    .push_ack(push_ack), .busy(busy), .push_count(push_count), .timeout_count(timeout_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  function automatic int idx_of(input logic [N-1:0] v);
    int r;
    r = -1;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  // ---------------- reference model: one transaction per call ----------------
  logic          m_req  = 1'b0;
  logic [N-1:0]  m_ack  = '0;
  logic [N-1:0]  m_err  = '0;
  logic          m_busy = 1'b0;
  logic [CW-1:0] m_chip = '0;
  logic [MW-1:0] m_msg  = '0;
  logic [15:0]   m_pc   = '0;
  logic [15:0]   m_tc   = '0;
  int            m_last = N - 1;

  task automatic m_edge(output bit r);
    @(posedge clk);
    r = rst;
    if (r) begin
      m_req = 1'b0; m_ack = '0; m_err = '0; m_busy = 1'b0;
      m_chip = '0; m_msg = '0; m_pc = '0; m_tc = '0; m_last = N - 1;
    end
  endtask

  task automatic m_txn();
    bit r;
    int g;
    int c;
    do begin
      m_edge(r);
    end while (r || (src_request == '0));
    g = -1;
    for (int k = 1; k <= N; k++) begin
      if (g < 0 && src_request[(m_last + k) % N]) g = (m_last + k) % N;
    end
    m_chip = src_chip_id[g*CW +: CW];
    m_msg  = src_message[g*MW +: MW];
    m_req  = 1'b1;
    m_busy = 1'b1;
    c = 0;
    forever begin
      m_edge(r);
      if (r) return;
      if (push_ack) begin
        m_req = 1'b0;
        m_pc  = m_pc + 16'd1;
        break;
      end
      if (c == T - 1) begin
        m_req = 1'b0;
        if (m_tc != 16'hFFFF) m_tc = m_tc + 16'd1;
        m_err = onehot(g);
        break;
      end
      c++;
    end
    if (m_err == '0) begin
      forever begin
        m_edge(r);
        if (r) return;
        if (!push_ack) break;
      end
      m_ack = onehot(g);
    end
    forever begin
      m_edge(r);
      if (r) return;
      if (!src_request[g]) break;
    end
    m_ack = '0; m_err = '0; m_busy = 1'b0; m_last = g;
  endtask

  initial forever m_txn();

  // Every-cycle comparison of the DUT against the model.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      check("push_request", 64'(push_request), 64'(m_req));
      check("src_ack", 64'(src_ack), 64'(m_ack));
      check("src_error", 64'(src_error), 64'(m_err));
      check("busy", 64'(busy), 64'(m_busy));
      check("push_chip_id", 64'(push_chip_id), 64'(m_chip));
      check("push_message", push_message, m_msg);
      check("push_count", 64'(push_count), 64'(m_pc));
      check("timeout_count", 64'(timeout_count), 64'(m_tc));
    end
  end

  // ---------------- queue responder ----------------
  bit ack_en      = 1'b1;
  bit rnd_ack     = 1'b0;
  int fixed_delay = 0;
  int cur_delay   = 0;
  int wait_cnt    = 0;
  int rel_cnt     = 0;

  initial forever begin
    @(posedge clk);
    #1;
    if (rst) begin
      push_ack = 1'b0;
      wait_cnt = 0;
    end else if (!push_request) begin
      wait_cnt  = 0;
      cur_delay = int'($urandom_range(0, 19));
      if (push_ack) begin
        if (rel_cnt == 0) push_ack = 1'b0;
        else rel_cnt--;
      end
    end else if (!push_ack) begin
      if (ack_en && wait_cnt == (rnd_ack ? cur_delay : fixed_delay)) begin
        push_ack = 1'b1;
        rel_cnt  = rnd_ack ? int'($urandom_range(0, 2)) : 0;
      end else begin
        wait_cnt++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_src(input int i, input logic [CW-1:0] chip, input logic [MW-1:0] msg);
    src_chip_id[i*CW +: CW] = chip;
    src_message[i*MW +: MW] = msg;
    src_request[i] = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    src_request = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic src_step(input int start_pct, input int drop_pct, input int wd_pm);
    for (int i = 0; i < N; i++) begin
      if (!src_request[i]) begin
        if (int'($urandom_range(0, 99)) < start_pct)
          set_src(i, CW'($urandom), {$urandom, $urandom});
      end else if (src_ack[i] || src_error[i]) begin
        if (int'($urandom_range(0, 99)) < drop_pct) src_request[i] = 1'b0;
      end else if (int'($urandom_range(0, 999)) < wd_pm) begin
        src_request[i] = 1'b0;
      end
    end
  endtask

  task automatic wait_resp(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((src_ack | src_error) == '0 && n < 200);
    check({name, "_resp_wait"}, 64'((src_ack | src_error) == '0), 64'(0));
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 200);
    check({name, "_idle_wait"}, 64'(busy), 64'(0));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cnt;
    int k;
    int idx;
    logic [N-1:0] prev_ack;

    tick();
    tick();
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_push_request", 64'(push_request), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));
    check("rst_push_count", 64'(push_count), 64'(0));
    check("rst_src_ack", 64'(src_ack), 64'(0));

    // Single request from source 2, acked after 3 cycles.
    fixed_delay = 3;
    tick();
    rst = 1'b0;
    set_src(2, 8'h2A, 64'h1234);
    @(negedge clk);
    check("single_pre_grant", 64'(push_request), 64'(0));
    @(negedge clk);
    check("single_push_req", 64'(push_request), 64'(1));
    check("single_chip", 64'(push_chip_id), 64'h2A);
    check("single_msg", push_message, 64'h1234);
    wait_resp("single");
    check("single_ack", 64'(src_ack), 64'(4'b0100));
    check("single_count", 64'(push_count), 64'(1));
    tick();
    src_request = '0;
    wait_idle("single");

    // Round-robin with all sources requesting continuously.
    fixed_delay = 1;
    do_reset();
    k = 0;
    cnt = 0;
    prev_ack = '0;
    while (k < 5 && cnt < 500) begin
      src_step(100, 100, 0);
      tick();
      cnt++;
      if (src_ack != '0 && prev_ack == '0) begin
        idx = idx_of(src_ack);
        check("rr_order", 64'(idx), 64'(k % N));
        k++;
      end
      prev_ack = src_ack;
    end
    check("rr_done", 64'(k), 64'(5));
    src_request = '0;
    wait_idle("rr");

    // Timeout: queue never acknowledges.
    ack_en = 1'b0;
    do_reset();
    set_src(1, 8'h11, 64'hABCD);
    cnt = 0;
    k = 0;
    do begin
      @(negedge clk);
      if (push_request) cnt++;
      k++;
    end while (src_error == '0 && k < 100);
    check("tmo_push_cycles", 64'(cnt), 64'(T));
    check("tmo_error", 64'(src_error), 64'(4'b0010));
    check("tmo_ack", 64'(src_ack), 64'(0));
    check("tmo_timeout_count", 64'(timeout_count), 64'(1));
    check("tmo_push_count", 64'(push_count), 64'(0));
    tick();
    src_request = '0;
    wait_idle("tmo");

    // Ack arrives on the last allowed PUSH cycle.
    ack_en = 1'b1;
    fixed_delay = T - 1;
    do_reset();
    set_src(3, 8'h33, 64'h5555);
    wait_resp("last");
    check("last_ack", 64'(src_ack), 64'(4'b1000));
    check("last_error", 64'(src_error), 64'(0));
    check("last_timeout_count", 64'(timeout_count), 64'(0));
    check("last_push_count", 64'(push_count), 64'(1));
    tick();
    src_request = '0;
    wait_idle("last");

    // Source 1 withdraws while its push is in flight.
    fixed_delay = 5;
    do_reset();
    set_src(1, 8'h77, 64'hBEEF);
    tick();
    tick();
    src_request[1] = 1'b0;
    wait_resp("wd");
    check("wd_ack", 64'(src_ack), 64'(4'b0010));
    check("wd_push_count", 64'(push_count), 64'(1));
    @(negedge clk);
    check("wd_pulse", 64'(src_ack), 64'(0));
    wait_idle("wd");

    // Reset in the middle of a push.
    ack_en = 1'b0;
    do_reset();
    set_src(2, 8'h22, 64'h2222);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("mid_rst_push_request", 64'(push_request), 64'(0));
    check("mid_rst_timeout_count", 64'(timeout_count), 64'(0));
    check("mid_rst_busy", 64'(busy), 64'(0));
    ack_en = 1'b1;
    fixed_delay = 0;
    tick();
    rst = 1'b0;
    set_src(0, 8'h01, 64'h0101);
    wait_resp("mid_rst");
    check("mid_rst_next_grant", 64'(src_ack), 64'(4'b0001));
    tick();
    src_request = '0;
    wait_idle("mid_rst");

    // Randomized traffic with occasional resets.
    rnd_ack = 1'b1;
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 999) == 0);
      src_step(20, 50, 2);
      tick();
    end
    rst = 1'b0;
    src_request = '0;
    wait_idle("rand");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

endmodule
